// File: rtl/rc_packet_ctrl.sv
// Receive-side packet sequencer: arms the DP/DM receiver, gates the SIPO, checks
// the PID and framing, and reports one completion status per receive request.
module rc_packet_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_BYTES      = 66
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_req,
    input  logic       rx_kind,
    input  logic       got_sync,
    input  logic       EOP_error,
    input  logic       bit_valid,
    input  logic       stuff_error,
    input  logic       eop_seen,
    input  logic [7:0] sipo_q,
    output logic       receive_hshake,
    output logic       receive_data,
    output logic       abort,
    output logic       sipo_en,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [3:0] rx_pid,
    output logic       rx_done,
    output logic       rx_ok,
    output logic [2:0] rx_err,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(MAX_BYTES + 2);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BYTE_MAX   = BW'(MAX_BYTES);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_PID     = 3'd2;
    localparam logic [2:0] ERR_KIND    = 3'd3;
    localparam logic [2:0] ERR_LENGTH  = 3'd4;
    localparam logic [2:0] ERR_ALIGN   = 3'd5;
    localparam logic [2:0] ERR_BUS     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_SYNC = 3'd1,
        S_PID       = 3'd2,
        S_WAIT_EOP  = 3'd3,
        S_BODY      = 3'd4,
        S_DONE      = 3'd5,
        S_ABORT     = 3'd6
    } state_t;

    state_t          r_state;
    logic            r_kind;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_cnt;
    logic [BW-1:0]   r_byte_cnt;
    logic            r_byte_ready;
    logic [7:0]      r_byte_out;
    logic [3:0]      r_rx_pid;
    logic            r_rx_ok;
    logic [2:0]      r_rx_err;

    logic [7:0]      w_byte;
    logic            w_rx_active;
    logic            w_armed;
    logic            w_bus_err;
    logic            w_overflow;
    logic [BW-1:0]   w_cnt_after;

    // The SIPO shifts left, so the first wire bit (the byte's LSB) sits in sipo_q[7].
    assign w_byte = {sipo_q[0], sipo_q[1], sipo_q[2], sipo_q[3],
                     sipo_q[4], sipo_q[5], sipo_q[6], sipo_q[7]};

    assign w_rx_active = (r_state == S_PID) || (r_state == S_WAIT_EOP) || (r_state == S_BODY);
    assign w_armed     = (r_state == S_WAIT_SYNC) || (r_state == S_PID) || (r_state == S_WAIT_EOP);
    assign w_bus_err   = (EOP_error || stuff_error) && (w_armed || (r_state == S_BODY));
    assign w_overflow  = (r_byte_cnt == BYTE_MAX);

    // A bit arriving alongside the EOP is not part of the packet and is dropped.
    assign sipo_en     = bit_valid && w_rx_active && !eop_seen;
    assign byte_valid  = !rst && (r_state == S_BODY) && r_byte_ready && !w_bus_err && !w_overflow;
    assign byte_out    = byte_valid ? w_byte : r_byte_out;
    assign w_cnt_after = byte_valid ? (r_byte_cnt + BW'(1)) : r_byte_cnt;

    assign receive_hshake = w_armed && !r_kind;
    assign receive_data   = (w_armed || (r_state == S_BODY)) && r_kind;
    assign abort          = (r_state == S_ABORT);
    assign rx_done        = (r_state == S_DONE) || (r_state == S_ABORT);
    assign busy           = (r_state != S_IDLE);
    assign rx_pid         = r_rx_pid;
    assign rx_ok          = r_rx_ok;
    assign rx_err         = r_rx_err;
    assign dbg_state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_kind       <= 1'b0;
            r_timer      <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_byte_ready <= 1'b0;
            r_byte_out   <= '0;
            r_rx_pid     <= '0;
            r_rx_ok      <= 1'b0;
            r_rx_err     <= ERR_NONE;
        end else begin
            r_byte_ready <= sipo_en && (r_bit_cnt == 3'd7);
            if (sipo_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (byte_valid) begin
                r_byte_out <= w_byte;
                r_byte_cnt <= w_cnt_after;
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_req) begin
                        r_kind     <= rx_kind;
                        r_rx_ok    <= 1'b0;
                        r_rx_err   <= ERR_NONE;
                        r_rx_pid   <= '0;
                        r_timer    <= '0;
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_state    <= S_WAIT_SYNC;
                    end
                end
                S_WAIT_SYNC: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_bus_err) begin
                        r_rx_err <= ERR_BUS;
                        r_state  <= S_ABORT;
                    end else if ((r_timer == TIMER_LAST) && !got_sync) begin
                        r_rx_err <= ERR_TIMEOUT;
                        r_state  <= S_ABORT;
                    end else if (got_sync) begin
                        r_state <= S_PID;
                    end
                end
                S_PID: begin
                    if (w_bus_err) begin
                        r_rx_err <= ERR_BUS;
                        r_state  <= S_ABORT;
                    end else if (r_byte_ready) begin
                        r_rx_pid <= w_byte[3:0];
                        if (w_byte[7:4] != ~w_byte[3:0]) begin
                            r_rx_err <= ERR_PID;
                            r_state  <= S_ABORT;
                        end else if (w_byte[1:0] != (r_kind ? 2'b11 : 2'b10)) begin
                            r_rx_err <= ERR_KIND;
                            r_state  <= S_ABORT;
                        end else begin
                            r_state <= r_kind ? S_BODY : S_WAIT_EOP;
                        end
                    end
                end
                S_WAIT_EOP: begin
                    if (w_bus_err) begin
                        r_rx_err <= ERR_BUS;
                        r_state  <= S_ABORT;
                    end else if (eop_seen) begin
                        r_rx_ok <= 1'b1;
                        r_state <= S_DONE;
                    end else if (bit_valid) begin
                        r_rx_err <= ERR_LENGTH;
                        r_state  <= S_ABORT;
                    end
                end
                S_BODY: begin
                    // A byte completing in the EOP cycle is counted before the framing checks.
                    if (w_bus_err) begin
                        r_rx_err <= ERR_BUS;
                        r_state  <= S_ABORT;
                    end else if (eop_seen) begin
                        if (r_byte_ready && w_overflow) begin
                            r_rx_err <= ERR_LENGTH;
                            r_state  <= S_ABORT;
                        end else if (r_bit_cnt != 3'd0) begin
                            r_rx_err <= ERR_ALIGN;
                            r_state  <= S_ABORT;
                        end else if (w_cnt_after < BW'(2)) begin
                            r_rx_err <= ERR_LENGTH;
                            r_state  <= S_ABORT;
                        end else begin
                            r_rx_ok <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (r_byte_ready && w_overflow) begin
                        r_rx_err <= ERR_LENGTH;
                        r_state  <= S_ABORT;
                    end
                end
                S_DONE, S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
